simon_arbiter: RTL
==================

# simon_arbiter

Round-robin arbiter and sequencer that shares one iterative SIMON encryption core between two independent requesters. Each requester hands over a plaintext block and key with a valid/ready handshake. The arbiter drives the core's `newData` load protocol, waits for the core's `done`, and returns the ciphertext on that requester's own response channel. It sits between the core and its clients, and it owns all core sequencing, including the dummy encryption the core runs after reset.

## Interface
- `N`, 16, word size in bits (block is 2N)
- `M`, 4, key words
- `T`, 32, core round count (used only for the watchdog limit)
- `W`, 8, watchdog counter width; must satisfy 2^W > T+8

- `clk`  in  1  clock; all logic is on the rising edge
- `nR`  in  1  reset, synchronous, active-low; also drives the core's `nR`
- `req_valid[i]`  in  1  requester i (i=0,1) offers a block
- `req_ready[i]`  out  1  arbiter accepts requester i's block this cycle
- `req_plain[i]`  in  2N  plaintext from requester i
- `req_key[i]`  in  M*N  key from requester i, word 0 in the LSBs
- `rsp_valid[i]`  out  1  ciphertext is available for requester i
- `rsp_ready[i]`  in  1  requester i takes the ciphertext
- `rsp_cipher[i]`  out  2N  ciphertext for requester i
- `core_newData`  out  1  load strobe to the core
- `core_plain`  out  2N  registered plaintext to the core
- `core_key`  out  M*N  registered key to the core
- `core_done`  in  1  core finished flag
- `core_cipher`  in  2N  core result
- `busy`  out  1  a transaction is in flight (state is not IDLE)
- `err`  out  1  sticky watchdog error

## Operation
- **States:** BOOT, IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- **BOOT** (entered on reset): wait for `core_done`=1, which marks the end of the core's post-reset dummy run, then go to IDLE.
- **Eligibility:** requester i is eligible when `req_valid[i]`=1 and `rsp_valid[i]`=0. A requester with an unconsumed response is never granted.
- **Grant:** round-robin with a one-bit pointer `last`.
  - If both requesters are eligible, grant the one that is not `last`.
  - If only one is eligible, grant it.
  - `last` resets to 1, so requester 0 wins the first tie.
- **`req_ready`:** combinational, = (state==IDLE) & granted. At most one requester is ready in any cycle.
- **Accept** (valid & ready):
  - Register plain and key into `core_plain`/`core_key`.
  - Record the owner id and set `last` to the owner.
  - Go to ISSUE.
- **ISSUE:** `core_newData`=1 for exactly one cycle, then go to WAIT_LOW.
- **WAIT_LOW:** stay until `core_done`=0, then go to WAIT_HIGH.
- **WAIT_HIGH:** when `core_done`=1, capture `core_cipher` into `rsp_cipher[owner]`, set `rsp_valid[owner]`, and go to IDLE.
- **Response channel:** `rsp_valid[i]` is held until `rsp_ready[i]`=1. It clears on that edge.
- **Stability:** `core_plain`/`core_key` hold from accept until the next accept. The core samples them one cycle after `newData`.
- **Watchdog:**
  - A W-bit counter clears on entering ISSUE and increments in ISSUE, WAIT_LOW and WAIT_HIGH.
  - If it reaches T+8: set `err`, drop the transaction (no response), and return to BOOT.
  - `err` clears only on reset.
- **Simultaneous accept and response consume:** both happen in the same cycle. Owner i may be re-granted in the cycle its `rsp_ready` fires only if `rsp_valid[i]` was already 0 at that cycle, i.e. eligibility uses registered `rsp_valid`.

## Timing
- **Reset values:** state=BOOT, `req_ready`=0, `rsp_valid`=0, `rsp_cipher`=0, `core_newData`=0, `core_plain`=0, `core_key`=0, `busy`=1 (BOOT counts as busy), `err`=0, `last`=1.
- **Latency, accept at cycle a:**
  - `core_newData` high in cycle a+1.
  - Core loads in a+2.
  - `core_done` low from a+3.
  - `core_done` high at a+T+3.
  - `rsp_valid` high at a+T+4, i.e. 36 cycles for T=32.
- **Next grant:** the earliest next `req_ready` is cycle a+T+4, same cycle as the response. Throughput is one block per T+4 cycles.
- **Reset mid-operation:** any state returns to BOOT on the next edge. Pending responses are discarded and `rsp_valid` clears. The core is reset by the same `nR`, so BOOT again waits out its dummy run.
- **No early done:** `core_done` high during ISSUE or WAIT_LOW is ignored as stale from the previous block.

## Test plan
- **Single request:** reset, release, wait for BOOT to exit. Requester 0 sends plain 0x65656877 with key 0x1918_1110_0908_0100 -> `req_ready[0]` for exactly 1 cycle, `core_newData` 1-cycle pulse, `rsp_valid[0]` exactly 36 cycles after accept, `rsp_cipher[0]`=0xc69be9bb.
- **Tie, round-robin:** both requesters valid continuously -> grants alternate 0,1,0,1 with accepts 36 cycles apart, and each response goes to the correct channel.
- **Backpressure:** hold `rsp_ready[1]`=0 with both requesters valid -> requester 1 is not granted again until its response is consumed, and requester 0 is served back-to-back in the meantime.
- **Mid-operation reset:** assert `nR`=0 during WAIT_HIGH -> next edge shows all outputs at reset values. No response is ever issued for the aborted block, and a new request completes normally after BOOT.
- **Watchdog:** stub core that never raises `core_done` after the load -> `err`=1 at T+8 cycles after entering ISSUE, state returns to BOOT, `rsp_valid` stays 0.
- **Stale done:** stub core that holds `done`=1 for 3 cycles after `newData` before dropping it -> the arbiter waits in WAIT_LOW and does not capture early.

Source files
------------

// File: rtl/simon_arbiter.sv
// Round-robin arbiter that shares one iterative SIMON core between two requesters.
// It sequences the core's newData/done protocol and returns each result on the owner's response channel.
module simon_arbiter #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][2*N-1:0]   req_plain,
    input  logic [1:0][M*N-1:0]   req_key,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [1:0][2*N-1:0]   rsp_cipher,
    output logic                  core_newData,
    output logic [2*N-1:0]        core_plain,
    output logic [M*N-1:0]        core_key,
    input  logic                  core_done,
    input  logic [2*N-1:0]        core_cipher,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    // The counter is compared before it increments, so T+7 here means T+8 cycles after ISSUE.
    localparam logic [W-1:0] WD_LAST = W'(T + 7);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                err_q, err_d;
    logic [W-1:0]        wd_q, wd_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0][2*N-1:0] rsp_cipher_q, rsp_cipher_d;
    logic [2*N-1:0]      plain_q, plain_d;
    logic [M*N-1:0]      key_q, key_d;

    logic [1:0]          elig;
    logic [1:0]          grant;
    logic                active;
    logic                timeout;
    logic                acc_id;

    // A requester still holding an unconsumed response is never eligible.
    always_comb begin
        elig  = req_valid & ~rsp_valid_q;
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign active    = (state_q == ISSUE) || (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    assign timeout   = active && (wd_q == WD_LAST);
    assign acc_id    = req_ready[1];

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        err_d        = err_q;
        wd_d         = wd_q;
        rsp_valid_d  = rsp_valid_q & ~rsp_ready;
        rsp_cipher_d = rsp_cipher_q;
        plain_d      = plain_q;
        key_d        = key_q;

        if (active) begin
            wd_d = wd_q + 1'b1;
        end

        if (timeout) begin
            err_d   = 1'b1;
            state_d = BOOT;
        end else begin
            case (state_q)
                BOOT: begin
                    if (core_done) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        plain_d = req_plain[acc_id];
                        key_d   = req_key[acc_id];
                        owner_d = acc_id;
                        last_d  = acc_id;
                        wd_d    = '0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    state_d = WAIT_LOW;
                end
                // done still high here belongs to the previous block
                WAIT_LOW: begin
                    if (!core_done) begin
                        state_d = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (core_done) begin
                        rsp_cipher_d[owner_q] = core_cipher;
                        rsp_valid_d[owner_q]  = 1'b1;
                        state_d               = IDLE;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q      <= BOOT;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_cipher_q <= '0;
            plain_q      <= '0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_cipher_q <= rsp_cipher_d;
            plain_q      <= plain_d;
            key_q        <= key_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_cipher   = rsp_cipher_q;
    assign core_newData = (state_q == ISSUE);
    assign core_plain   = plain_q;
    assign core_key     = key_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

endmodule
